// File: rtl/div_unit_if.sv
// Request/response bundle between the EX stage and the divider.
// EX drives operands and start_i, the divider answers with result_o/ready_o.
interface div_unit_if #(
    parameter int DW = 32
);
    logic              signed_div_i;
    logic [DW-1:0]     opdata1_i;
    logic [DW-1:0]     opdata2_i;
    logic              start_i;
    logic              annul_i;
    logic [2*DW-1:0]   result_o;
    logic              ready_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o
    );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider, DW steps per op (divide-by-zero answers in 1); result held
// with ready_o until start_i drops, annul_i aborts while iterating.
module div_unit #(
    parameter int DW = 32
) (
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  div_if
);
    localparam int CW = $clog2(DW) + 1;

    typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CW-1:0]     r_cnt,    w_cnt_nxt;
    logic [DW-1:0]     r_rem,    w_rem_nxt;
    logic [DW-1:0]     r_quo,    w_quo_nxt;
    logic [DW-1:0]     r_dv,     w_dv_nxt;
    logic              r_signed, w_signed_nxt;
    logic              r_sign1,  w_sign1_nxt;
    logic              r_sign2,  w_sign2_nxt;
    logic [2*DW-1:0]   r_result, w_result_nxt;
    logic              r_ready;

    logic [DW-1:0]     w_abs1, w_abs2;
    logic [DW:0]       w_rem_sh, w_rem_diff;
    logic              w_ge, w_last, w_accept;
    logic [DW-1:0]     w_rem_step, w_quo_step, w_rem_fix, w_quo_fix;

    assign w_abs1 = (div_if.signed_div_i && div_if.opdata1_i[DW-1]) ? -div_if.opdata1_i : div_if.opdata1_i;
    assign w_abs2 = (div_if.signed_div_i && div_if.opdata2_i[DW-1]) ? -div_if.opdata2_i : div_if.opdata2_i;
    assign w_accept = div_if.start_i && !div_if.annul_i;

    // One restoring step; the DW+1-bit difference's top bit is the borrow.
    assign w_rem_sh   = {r_rem, r_quo[DW-1]};
    assign w_rem_diff = w_rem_sh - {1'b0, r_dv};
    assign w_ge       = !w_rem_diff[DW];
    assign w_rem_step = w_ge ? w_rem_diff[DW-1:0] : w_rem_sh[DW-1:0];
    assign w_quo_step = {r_quo[DW-2:0], w_ge};
    assign w_last     = (r_cnt == CW'(DW - 1));
    assign w_quo_fix  = (r_signed && (r_sign1 ^ r_sign2)) ? -w_quo_step : w_quo_step;
    assign w_rem_fix  = (r_signed && r_sign1) ? -w_rem_step : w_rem_step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_FREE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FREE:   if (w_accept) w_state_nxt = (div_if.opdata2_i == '0) ? S_BYZERO : S_ON;
            S_ON:     if (div_if.annul_i) w_state_nxt = S_FREE;
                      else if (w_last)    w_state_nxt = S_END;
            S_BYZERO: w_state_nxt = S_END;
            S_END:    if (!div_if.start_i) w_state_nxt = S_FREE;
            default:  w_state_nxt = S_FREE;
        endcase
    end

    always_comb begin
        w_cnt_nxt    = r_cnt;
        w_rem_nxt    = r_rem;
        w_quo_nxt    = r_quo;
        w_dv_nxt     = r_dv;
        w_signed_nxt = r_signed;
        w_sign1_nxt  = r_sign1;
        w_sign2_nxt  = r_sign2;
        w_result_nxt = r_result;
        case (r_state)
            S_FREE: begin
                if (w_accept) begin
                    w_signed_nxt = div_if.signed_div_i;
                    w_sign1_nxt  = div_if.opdata1_i[DW-1];
                    w_sign2_nxt  = div_if.opdata2_i[DW-1];
                    w_cnt_nxt    = '0;
                    w_rem_nxt    = '0;
                    w_quo_nxt    = w_abs1;
                    w_dv_nxt     = w_abs2;
                end
            end
            S_ON: begin
                if (!div_if.annul_i) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                    w_rem_nxt = w_rem_step;
                    w_quo_nxt = w_quo_step;
                    if (w_last) w_result_nxt = {w_rem_fix, w_quo_fix};
                end
            end
            S_BYZERO: w_result_nxt = '0;
            S_END:    if (!div_if.start_i) w_result_nxt = '0;
            default:  w_result_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dv     <= '0;
            r_signed <= 1'b0;
            r_sign1  <= 1'b0;
            r_sign2  <= 1'b0;
            r_result <= '0;
            r_ready  <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_rem    <= w_rem_nxt;
            r_quo    <= w_quo_nxt;
            r_dv     <= w_dv_nxt;
            r_signed <= w_signed_nxt;
            r_sign1  <= w_sign1_nxt;
            r_sign2  <= w_sign2_nxt;
            r_result <= w_result_nxt;
            r_ready  <= (w_state_nxt == S_END);
        end
    end

    assign div_if.result_o = r_result;
    assign div_if.ready_o  = r_ready;
endmodule

// File: tb/tb_div_unit.sv
// Directed divider vectors; expected results and ready cycles queued by the driver,
// popped and compared by a monitor on every rising ready_o.
module tb_div_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    div_unit_if #(.DW(32)) bus();
    div_unit #(.DW(32)) dut (.clk(clk), .rst(rst), .div_if(bus));

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [63:0] sb_res[$];
    int          sb_cyc[$];
    logic        prev_ready = 1'b0;
    logic [63:0] m_res;
    int          m_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.ready_o === 1'b1 && prev_ready !== 1'b1) begin
            if (sb_res.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_ready: result %h at cycle %0d, no request pending", bus.result_o, cyc);
            end else begin
                m_res = sb_res.pop_front();
                m_cyc = sb_cyc.pop_front();
                chk("result", bus.result_o, m_res);
                chk("ready_cycle", 64'(cyc), 64'(m_cyc));
            end
        end
        prev_ready = bus.ready_o;
    end

    task automatic do_div(input string nm, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int lat,
                          input int hold);
        int n;
        @(negedge clk);
        bus.signed_div_i = sgn;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.start_i      = 1'b1;
        sb_res.push_back(exp);
        sb_cyc.push_back(cyc + 1 + lat);
        @(negedge clk);
        bus.opdata1_i    = 32'hDEAD_BEEF;
        bus.opdata2_i    = 32'h0;
        bus.signed_div_i = ~sgn;
        n = 0;
        while (bus.ready_o !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.ready_o !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: ready_o %b required 1", nm, bus.ready_o);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({nm, "_hold_ready"}, 64'(bus.ready_o), 64'd1);
            chk({nm, "_hold_result"}, bus.result_o, exp);
        end
        bus.start_i = 1'b0;
        @(negedge clk);
        chk({nm, "_clear_ready"}, 64'(bus.ready_o), 64'd0);
        chk({nm, "_clear_result"}, bus.result_o, 64'd0);
    endtask

    task automatic expect_idle(input string nm, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.ready_o !== 1'b0) seen = 1'b1;
        end
        chk(nm, 64'(seen), 64'd0);
    endtask

    initial begin
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("reset_ready", 64'(bus.ready_o), 64'd0);
        chk("reset_result", bus.result_o, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        do_div("divu_100_7",  1'b0, 32'd100,       32'd7,         64'h00000002_0000000E, 32, 0);
        do_div("div_m7_2",    1'b1, 32'hFFFFFFF9,  32'd2,         64'hFFFFFFFF_FFFFFFFD, 32, 0);
        do_div("div_7_m2",    1'b1, 32'd7,         32'hFFFFFFFE,  64'h00000001_FFFFFFFD, 32, 0);
        do_div("divu_max_1",  1'b0, 32'hFFFFFFFF,  32'd1,         64'h00000000_FFFFFFFF, 32, 0);
        do_div("div_ovf",     1'b1, 32'h80000000,  32'hFFFFFFFF,  64'h00000000_80000000, 32, 0);
        do_div("divu_big",    1'b0, 32'h80000000,  32'hFFFFFFFF,  64'h80000000_00000000, 32, 0);
        do_div("div_m100_m7", 1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  64'hFFFFFFFE_0000000E, 32, 0);
        do_div("div_by_zero", 1'b0, 32'd5,         32'd0,         64'h0,                 1,  0);
        do_div("end_hold",    1'b0, 32'd100,       32'd7,         64'h00000002_0000000E, 32, 5);

        // Abort on the edge that would perform step 10.
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd50;
        bus.opdata2_i    = 32'd7;
        bus.start_i      = 1'b1;
        repeat (10) @(negedge clk);
        bus.annul_i = 1'b1;
        @(negedge clk);
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        chk("annul_result", bus.result_o, 64'd0);
        expect_idle("annul_no_ready", 40);
        do_div("after_annul", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 32, 0);

        // start together with annul in FREE must not be accepted.
        @(negedge clk);
        bus.opdata1_i = 32'd20;
        bus.opdata2_i = 32'd4;
        bus.start_i   = 1'b1;
        bus.annul_i   = 1'b1;
        repeat (3) @(negedge clk);
        bus.start_i = 1'b0;
        bus.annul_i = 1'b0;
        expect_idle("free_annul_no_ready", 40);

        // Asynchronous reset in the middle of iterating.
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd100;
        bus.opdata2_i    = 32'd7;
        bus.start_i      = 1'b1;
        repeat (15) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_on_ready", 64'(bus.ready_o), 64'd0);
        chk("rst_on_result", bus.result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.start_i = 1'b0;
        expect_idle("rst_on_no_ready", 40);

        // Asynchronous reset while a result is being held.
        @(negedge clk);
        bus.signed_div_i = 1'b1;
        bus.opdata1_i    = 32'd7;
        bus.opdata2_i    = 32'hFFFFFFFE;
        bus.start_i      = 1'b1;
        sb_res.push_back(64'h00000001_FFFFFFFD);
        sb_cyc.push_back(cyc + 33);
        for (int i = 0; i < 100 && bus.ready_o !== 1'b1; i++) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_end_ready", 64'(bus.ready_o), 64'd0);
        chk("rst_end_result", bus.result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.start_i = 1'b0;
        expect_idle("rst_end_no_ready", 5);
        do_div("after_rst", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 32, 0);

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 64'(sb_res.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d checks so far", n_vec);
        $fatal(1);
    end
endmodule
